// File: rtl/io_unit_responder_if.sv
// io_unit_responder_if: IO read/write port and TX sink bundle between the core side (master) and the responder (slave).
interface io_unit_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ioReadAddrIn;
    logic [DATA_WIDTH-1:0] ioReadDataOut;
    logic                  ioWriteEnable;
    logic [ADDR_WIDTH-1:0] ioWriteAddr;
    logic [DATA_WIDTH-1:0] ioWriteData;
    logic                  ioWriteReady;
    logic                  timerInterrupt;
    logic                  txValid;
    logic                  txReady;
    logic [7:0]            txData;
    modport master (
        output ioReadAddrIn, ioWriteEnable, ioWriteAddr, ioWriteData, txReady,
        input  ioReadDataOut, ioWriteReady, timerInterrupt, txValid, txData
    );
    modport slave (
        input  ioReadAddrIn, ioWriteEnable, ioWriteAddr, ioWriteData, txReady,
        output ioReadDataOut, ioWriteReady, timerInterrupt, txValid, txData
    );
endinterface

// File: rtl/io_unit_responder.sv
// io_unit_responder: memory-mapped 64-bit timer with compare IRQ and a byte TX FIFO.
// Define RSD_IO_TIMER_PRESCALE_EN to add the PRESCALE tick divider at offset 0x18.
module io_unit_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(32'h4000_0000),
    parameter int TX_FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    io_unit_responder_if.slave io
);
    localparam int PW = $clog2(TX_FIFO_DEPTH);
    logic [63:0]   mtime, mtimecmp, mtimeInc;
    logic          timerEnable, irqEnable, timerIrq, tick;
    logic [7:0]    fifo [TX_FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;
    logic          full, push, pop;
    logic          rdHit, wrHit, wrSel, wrReady;
    logic [11:0]   rdOff, wrOff;
    logic [31:0]   wd, rdWord, txStatus, prescaleWord;
`ifdef RSD_IO_TIMER_PRESCALE_EN
    logic [15:0]   prescale, divider;
    assign tick = timerEnable && divider == prescale;
    assign prescaleWord = {16'h0, prescale};
`else
    assign tick = timerEnable;
    assign prescaleWord = 32'h0;
`endif
    assign rdHit = io.ioReadAddrIn[ADDR_WIDTH-1:12] == IO_BASE[ADDR_WIDTH-1:12];
    assign wrHit = io.ioWriteAddr[ADDR_WIDTH-1:12] == IO_BASE[ADDR_WIDTH-1:12];
    assign rdOff = io.ioReadAddrIn[11:0];
    assign wrOff = io.ioWriteAddr[11:0];
    assign wd    = 32'(io.ioWriteData);
    assign full  = count == (PW+1)'(TX_FIFO_DEPTH);
    assign wrReady = !(wrHit && wrOff == 12'h010 && full);
    assign wrSel = io.ioWriteEnable && wrReady && wrHit;
    assign push  = wrSel && wrOff == 12'h010;
    assign pop   = io.txValid && io.txReady;
    assign mtimeInc = mtime + 64'(tick);
    assign txStatus = {16'h0, 8'(count), 6'h0, full, count == '0};
    // Reads are pure decode so flushed/replayed loads never disturb state.
    assign rdWord = !rdHit ? 32'h0 :
                    rdOff == 12'h000 ? mtime[31:0] :
                    rdOff == 12'h004 ? mtime[63:32] :
                    rdOff == 12'h008 ? mtimecmp[31:0] :
                    rdOff == 12'h00C ? mtimecmp[63:32] :
                    rdOff == 12'h010 ? txStatus :
                    rdOff == 12'h014 ? {30'h0, irqEnable, timerEnable} :
                    rdOff == 12'h018 ? prescaleWord : 32'h0;
    assign io.ioReadDataOut  = DATA_WIDTH'(rdWord);
    assign io.ioWriteReady   = wrReady;
    assign io.timerInterrupt = timerIrq;
    assign io.txValid        = count != '0;
    assign io.txData         = fifo[head];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            timerEnable <= 1'b0;
            irqEnable   <= 1'b0;
            timerIrq    <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            // A half written this cycle overrides only that half of the incremented value.
            mtime <= {wrSel && wrOff == 12'h004 ? wd : mtimeInc[63:32],
                      wrSel && wrOff == 12'h000 ? wd : mtimeInc[31:0]};
            if (wrSel && wrOff == 12'h008) mtimecmp[31:0] <= wd;
            if (wrSel && wrOff == 12'h00C) mtimecmp[63:32] <= wd;
            if (wrSel && wrOff == 12'h014) {irqEnable, timerEnable} <= wd[1:0];
            timerIrq <= irqEnable && mtime >= mtimecmp;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
`ifdef RSD_IO_TIMER_PRESCALE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            divider  <= '0;
        end else if (wrSel && wrOff == 12'h018) begin
            prescale <= wd[15:0];
            divider  <= '0;
        end else if (timerEnable) begin
            divider <= tick ? 16'h0 : divider + 16'h1;
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (push) fifo[tail] <= wd[7:0];
    end
endmodule

// File: tb/tb_io_unit_responder.sv
// tb_io_unit_responder: directed checks of the IO responder register map, timer and TX FIFO.
module tb_io_unit_responder;
    localparam logic [31:0] B = 32'h4000_0000;
    logic clk, rst;
    int checks = 0, errors = 0;
    logic [31:0] d;
    io_unit_responder_if bus();
    io_unit_responder dut (.clk(clk), .rst(rst), .io(bus));
    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        int n = 0;
        bus.ioWriteEnable = 1'b1; bus.ioWriteAddr = a; bus.ioWriteData = v;
        #1;
        while (!bus.ioWriteReady && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (n == 20) begin errors++; $display("FAIL wr_timeout addr=%h ready stayed 0", a); end
        @(negedge clk);
        bus.ioWriteEnable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.ioReadAddrIn = a;
        #1;
        v = bus.ioReadDataOut;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (bus.txValid !== 1'b0) begin errors++; $display("FAIL rst_txValid got %b exp 0", bus.txValid); end
        checks++; if (bus.timerInterrupt !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.timerInterrupt); end
        repeat (2) @(negedge clk);
        rd(B + 32'h08, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmplo got %h exp ffffffff", d); end
        rd(B + 32'h0C, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmphi got %h exp ffffffff", d); end
        rd(B + 32'h10, d); checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL rst_tx got %h exp 00000001", d); end
        rd(B + 32'h14, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", d); end
        rd(B + 32'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mtime got %h exp 0", d); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_timer_irq();
        wr(B + 32'h14, 32'h3);
        wr(B + 32'h0C, 32'h0);
        wr(B + 32'h08, 32'd10);
        wr(B + 32'h04, 32'h0);
        wr(B + 32'h00, 32'h0);
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'd10) begin errors++; $display("FAIL tmr_reach got %0d exp 10", d); end
        checks++; if (bus.timerInterrupt !== 1'b0) begin errors++; $display("FAIL tmr_irq_early got %b exp 0", bus.timerInterrupt); end
        @(negedge clk);
        checks++; if (bus.timerInterrupt !== 1'b1) begin errors++; $display("FAIL tmr_irq_rise got %b exp 1", bus.timerInterrupt); end
        wr(B + 32'h08, 32'd100);
        checks++; if (bus.timerInterrupt !== 1'b1) begin errors++; $display("FAIL tmr_irq_lag got %b exp 1", bus.timerInterrupt); end
        @(negedge clk);
        #1;
        checks++; if (bus.timerInterrupt !== 1'b0) begin errors++; $display("FAIL tmr_irq_drop got %b exp 0", bus.timerInterrupt); end
    endtask

    task automatic test_carry();
        wr(B + 32'h14, 32'h1);
        wr(B + 32'h04, 32'h0);
        wr(B + 32'h00, 32'hFFFF_FFFF);
        rd(B + 32'h00, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cy_lo0 got %h exp ffffffff", d); end
        rd(B + 32'h04, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL cy_hi0 got %h exp 0", d); end
        @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL cy_lo1 got %h exp 0", d); end
        rd(B + 32'h04, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL cy_hi1 got %h exp 1", d); end
        wr(B + 32'h00, 32'hFFFF_FFFF);
        wr(B + 32'h04, 32'h7);
        rd(B + 32'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL cy_ovr_lo got %h exp 0", d); end
        rd(B + 32'h04, d); checks++; if (d !== 32'h7) begin errors++; $display("FAIL cy_ovr_hi got %h exp 7", d); end
        wr(B + 32'h14, 32'h0);
        @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL cy_frozen got %h exp 1", d); end
    endtask

    task automatic test_tx_full();
        bus.txReady = 1'b0;
        for (int i = 0; i < 4; i++) wr(B + 32'h10, 32'h41 + i);
        rd(B + 32'h10, d); checks++; if (d !== 32'h0402) begin errors++; $display("FAIL tx_full_status got %h exp 0402", d); end
        checks++; if (bus.txData !== 8'h41) begin errors++; $display("FAIL tx_head got %h exp 41", bus.txData); end
        bus.ioWriteEnable = 1'b1; bus.ioWriteAddr = B + 32'h10; bus.ioWriteData = 32'h45;
        #1;
        checks++; if (bus.ioWriteReady !== 1'b0) begin errors++; $display("FAIL tx_refuse got %b exp 0", bus.ioWriteReady); end
        @(negedge clk);
        rd(B + 32'h10, d); checks++; if (d !== 32'h0402) begin errors++; $display("FAIL tx_hold got %h exp 0402", d); end
        bus.txReady = 1'b1;
        #1;
        checks++; if (bus.ioWriteReady !== 1'b0) begin errors++; $display("FAIL tx_popfull_ready got %b exp 0", bus.ioWriteReady); end
        @(negedge clk);
        bus.txReady = 1'b0;
        rd(B + 32'h10, d); checks++; if (d !== 32'h0300) begin errors++; $display("FAIL tx_after_pop got %h exp 0300", d); end
        checks++; if (bus.ioWriteReady !== 1'b1 || bus.txData !== 8'h42) begin errors++; $display("FAIL tx_ready_again got rdy=%b head=%h exp rdy=1 head=42", bus.ioWriteReady, bus.txData); end
        @(negedge clk);
        bus.ioWriteEnable = 1'b0;
        rd(B + 32'h10, d); checks++; if (d !== 32'h0402) begin errors++; $display("FAIL tx_fifth_in got %h exp 0402", d); end
        bus.txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.txValid !== 1'b1 || bus.txData !== 8'(8'h42 + i)) begin errors++; $display("FAIL tx_drain%0d got v=%b d=%h exp v=1 d=%h", i, bus.txValid, bus.txData, 8'(8'h42 + i)); end
            @(negedge clk);
        end
        bus.txReady = 1'b0;
        rd(B + 32'h10, d); checks++; if (d !== 32'h1 || bus.txValid !== 1'b0) begin errors++; $display("FAIL tx_empty got %h v=%b exp 00000001 v=0", d, bus.txValid); end
    endtask

    task automatic test_back_to_back();
        wr(B + 32'h10, 32'h50);
        checks++; if (bus.txValid !== 1'b1 || bus.txData !== 8'h50) begin errors++; $display("FAIL b2b_first got v=%b d=%h exp v=1 d=50", bus.txValid, bus.txData); end
        bus.txReady = 1'b1;
        bus.ioWriteEnable = 1'b1; bus.ioWriteAddr = B + 32'h10; bus.ioWriteData = 32'h51;
        @(negedge clk);
        bus.ioWriteEnable = 1'b0; bus.txReady = 1'b0;
        rd(B + 32'h10, d); checks++; if (d !== 32'h0100 || bus.txData !== 8'h51) begin errors++; $display("FAIL b2b_pushpop got %h d=%h exp 0100 d=51", d, bus.txData); end
        bus.txReady = 1'b1;
        @(negedge clk);
        bus.txReady = 1'b0;
        #1;
        checks++; if (bus.txValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", bus.txValid); end
    endtask

    task automatic test_unmapped();
        rd(B + 32'h1C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL um_1c got %h exp 0", d); end
        rd(32'h4000_1000, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL um_outside got %h exp 0", d); end
        rd(32'h0000_0008, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL um_low got %h exp 0", d); end
        bus.ioWriteAddr = 32'h4000_1008;
        #1;
        checks++; if (bus.ioWriteReady !== 1'b1) begin errors++; $display("FAIL um_ready got %b exp 1", bus.ioWriteReady); end
        wr(32'h4000_1008, 32'h5);
        rd(B + 32'h08, d); checks++; if (d !== 32'd100) begin errors++; $display("FAIL um_ignored got %h exp 64", d); end
    endtask

    task automatic test_prescale();
        wr(B + 32'h18, 32'h3);
`ifdef RSD_IO_TIMER_PRESCALE_EN
        rd(B + 32'h18, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL ps_read got %h exp 3", d); end
        wr(B + 32'h14, 32'h1);
        wr(B + 32'h00, 32'h0);
        repeat (2) @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ps_hold got %0d exp 0", d); end
        @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL ps_tick1 got %0d exp 1", d); end
        repeat (3) @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL ps_hold2 got %0d exp 1", d); end
        @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h2) begin errors++; $display("FAIL ps_tick2 got %0d exp 2", d); end
`else
        rd(B + 32'h18, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ps_read got %h exp 0", d); end
        wr(B + 32'h14, 32'h1);
        wr(B + 32'h00, 32'h0);
        rd(B + 32'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL ps_start got %0d exp 0", d); end
        @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL ps_tick1 got %0d exp 1", d); end
        repeat (3) @(negedge clk);
        rd(B + 32'h00, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL ps_tick4 got %0d exp 4", d); end
`endif
        wr(B + 32'h14, 32'h0);
    endtask

    task automatic test_reset_mid();
        wr(B + 32'h10, 32'h60);
        wr(B + 32'h10, 32'h61);
        checks++; if (bus.txValid !== 1'b1) begin errors++; $display("FAIL rm_pre got %b exp 1", bus.txValid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.txValid !== 1'b0) begin errors++; $display("FAIL rm_async got %b exp 0", bus.txValid); end
        @(negedge clk);
        rst = 1'b0;
        rd(B + 32'h10, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL rm_tx got %h exp 1", d); end
        rd(B + 32'h0C, d); checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rm_cmphi got %h exp ffffffff", d); end
        rd(B + 32'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_mtime got %h exp 0", d); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        bus.ioReadAddrIn = '0; bus.ioWriteEnable = 1'b0; bus.ioWriteAddr = '0;
        bus.ioWriteData = '0; bus.txReady = 1'b0;
        #2;
        test_reset();
        test_timer_irq();
        test_carry();
        test_tx_full();
        test_back_to_back();
        test_unmapped();
        test_prescale();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_unit_responder.md
Name: io_unit_responder

Overview:
- Memory-mapped IO responder on the far side of the load pipeline's IO read port (lane 0 only) and of the committed-store IO write port.
- Holds a 64-bit machine timer with compare/interrupt and a byte TX FIFO that drains to a serial/host sink.
- Reads are combinational and side-effect free, because loads may be flushed or replayed.
- Writes arrive only from committed stores.

Parameters:
ADDR_WIDTH, 32, physical address width of ioReadAddrIn/ioWriteAddr
DATA_WIDTH, 32, IO data word width
IO_BASE, 32'h4000_0000, base of the IO register window (4 KiB, offset = addr[11:0])
TX_FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
ioReadAddrIn  in  ADDR_WIDTH  load address from memory-access lane 0
ioReadDataOut  out  DATA_WIDTH  read data, same cycle as address
ioWriteEnable  in  1  committed store to IO valid
ioWriteAddr  in  ADDR_WIDTH  store address (word aligned)
ioWriteData  in  DATA_WIDTH  store data
ioWriteReady  out  1  store accepted this cycle when high with ioWriteEnable
timerInterrupt  out  1  registered timer interrupt request
txValid  out  1  TX byte available
txReady  in  1  sink accepts byte
txData  out  8  TX byte (FIFO head)

Behaviour:
- Register map (offset from IO_BASE):
  - 0x00 MTIME_LO RW; 0x04 MTIME_HI RW; 0x08 MTIMECMP_LO RW; 0x0C MTIMECMP_HI RW.
  - 0x10 TX: write pushes data[7:0]; read returns {count in [15:8], full in bit1, empty in bit0}.
  - 0x14 CTRL RW: bit0 timerEnable, bit1 irqEnable; other bits read 0.
  - 0x18 PRESCALE (see Optional Feature). Unmapped offsets or addresses outside the window read 0; writes to them are accepted and ignored.
- Reset (async, outputs valid immediately): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, FIFO empty (ptrs/count=0), txValid=0, timerInterrupt=0.
- Read: pure combinational decode of ioReadAddrIn; no state changes on read (no pop, no clear).
- Write handshake: ioWriteReady = !(target is TX && FIFO full). A write takes effect on the clk edge where ioWriteEnable && ioWriteReady. The store pipeline holds the write until then.
- Timer: when timerEnable, mtime increments by 1 per tick (64-bit, wraps to 0 after all-ones). A write to MTIME_LO/HI in the same cycle overrides that half; the other half keeps its incremented value, including carry.
- timerInterrupt register <= irqEnable && (mtime >= mtimecmp), computed from current register values. It therefore lags a mtime/mtimecmp write by 1 cycle. Writing mtimecmp above mtime deasserts it the next cycle.
- TX FIFO:
  - txValid = count!=0; txData = head byte.
  - Pop on txValid && txReady.
  - Push and pop in the same cycle when full: push refused (ready low). When not full: both happen, count unchanged.
  - Push to empty FIFO: byte visible on txData the next cycle.
  - Pointers wrap modulo TX_FIFO_DEPTH.
- Reset mid-operation: FIFO contents discarded, txValid drops asynchronously.

Optional Feature:
- Macro RSD_IO_TIMER_PRESCALE_EN.
- Defined: 16-bit PRESCALE register at 0x18 (reset 0) and a 16-bit divider counter. A tick occurs when divider==PRESCALE; the divider then resets to 0, otherwise increments. PRESCALE=0 gives a tick every cycle. Writing PRESCALE also clears the divider.
- Undefined: every cycle is a tick; 0x18 reads 0 and writes are ignored.

Test Plan:
- Reset, read 0x08/0x0C -> 0xFFFF_FFFF each; 0x10 -> 0x0000_0001; txValid=0, timerInterrupt=0.
- Write CTRL=3, mtimecmp={0,10}, mtime=0 -> timerInterrupt rises exactly 1 cycle after mtime reaches 10; write MTIMECMP_LO=100 -> drops next cycle.
- Write MTIME_LO=0xFFFF_FFFF with MTIME_HI=0 and timer on -> next read {HI,LO}={1,0} (carry).
- Hold txReady=0, push 5 bytes 0x41..0x45 -> first 4 accepted; 5th sees ioWriteReady=0 until txReady=1 pops 0x41, then accepted; drain order 41,42,43,44,45.
- Full FIFO with simultaneous pop and push attempt -> pop occurs, push refused that cycle, count 4->3, push accepted next cycle.
- With RSD_IO_TIMER_PRESCALE_EN, PRESCALE=3 -> mtime increments once per 4 cycles; without the macro -> per cycle, 0x18 reads 0.
